// File: rtl/sobel_pkg.sv
// Shared definitions for the sobel frame controller: FSM states, threshold mode codes,
// the configuration record and the saturating helper used by the edge statistics.
package sobel_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VSYNC  = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        MODE_FIXED      = 2'b00,
        MODE_ADAPTIVE   = 2'b01,
        MODE_HYSTERESIS = 2'b10
    } mode_t;

    localparam logic [7:0] SOBEL_DEF_THRESHOLD = 8'd100;
    localparam int         EDGE_CNT_W          = 20;

    typedef struct packed {
        logic       sobel_en;
        logic [7:0] threshold;
        logic [1:0] mode;
    } cfg_t;

    function automatic logic [EDGE_CNT_W-1:0] sat_inc_edge(input logic [EDGE_CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/sobel_timing_cnt.sv
// Line/frame geometry counters for the sobel frame controller: column and row position,
// completed-frame count and the sticky line/frame length error flags.
module sobel_timing_cnt #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    localparam int COL_W     = $clog2(IMG_WIDTH + 1),
    localparam int ROW_W     = $clog2(IMG_HEIGHT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic             frame_start,
    input  logic             frame_end,
    input  logic             href,
    input  logic             err_clr,
    output logic [COL_W-1:0] col_count,
    output logic [ROW_W-1:0] row_count,
    output logic             frame_done,
    output logic [15:0]      frame_cnt,
    output logic             err_line,
    output logic             err_frame
);

    localparam logic [COL_W-1:0] WIDTH_MAX  = COL_W'(IMG_WIDTH);
    localparam logic [ROW_W-1:0] HEIGHT_MAX = ROW_W'(IMG_HEIGHT);

    logic href_d;
    logic line_end;
    logic line_bad;
    logic frame_bad;

    // href history only tracks the active window so a line straddling vsync never counts
    assign line_end  = active & href_d & ~href;
    assign line_bad  = line_end && (col_count != WIDTH_MAX);
    assign frame_bad = frame_end && (row_count != HEIGHT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            href_d    <= 1'b0;
            col_count <= '0;
            row_count <= '0;
        end else begin
            href_d <= active & href;

            if (!active || !href) begin
                col_count <= '0;
            end else if (col_count != WIDTH_MAX) begin
                col_count <= col_count + 1'b1;
            end

            if (frame_start) begin
                row_count <= '0;
            end else if (line_end && (row_count != HEIGHT_MAX)) begin
                row_count <= row_count + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            frame_done <= frame_end;
            if (frame_end) begin
                frame_cnt <= frame_cnt + 1'b1;
            end
        end
    end

    // A newly detected error wins over a simultaneous clear so it is never lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_line  <= 1'b0;
            err_frame <= 1'b0;
        end else begin
            if (line_bad) begin
                err_line <= 1'b1;
            end else if (err_clr) begin
                err_line <= 1'b0;
            end

            if (frame_bad) begin
                err_frame <= 1'b1;
            end else if (err_clr) begin
                err_frame <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame controller for the sobel edge pipeline: vsync/href FSM, frame-boundary configuration
// commit and optional per-frame edge statistics (enabled by defining SOBEL_CTRL_STATS_EN).
module sobel_frame_ctrl
    import sobel_pkg::*;
#(
    parameter int         IMG_WIDTH     = 640,
    parameter int         IMG_HEIGHT    = 480,
    parameter logic [7:0] DEF_THRESHOLD = SOBEL_DEF_THRESHOLD
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              vsync,
    input  logic                              href,
    input  logic                              cfg_valid,
    input  logic                              cfg_sobel_en,
    input  logic [7:0]                        cfg_threshold,
    input  logic [1:0]                        cfg_mode,
    output logic                              cfg_ack,
    output logic                              act_sobel_en,
    output logic [7:0]                        act_threshold,
    output logic [1:0]                        act_mode,
    input  logic                              binary_valid,
    input  logic                              binary_pixel,
    output logic                              frame_active,
    output logic [$clog2(IMG_WIDTH+1)-1:0]    col_count,
    output logic [$clog2(IMG_HEIGHT+1)-1:0]   row_count,
    output logic                              frame_done,
    output logic [15:0]                       frame_cnt,
    output logic                              err_line,
    output logic                              err_frame,
    input  logic                              err_clr,
    output logic [EDGE_CNT_W-1:0]             edge_count
);

    state_t state;
    state_t state_next;
    logic   frame_start;
    logic   frame_end;
    logic   commit;

    cfg_t   cfg_in;
    cfg_t   shadow;
    logic   pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Leaving IDLE or ACTIVE on a vsync rise is a frame boundary and the only commit point
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        commit      = 1'b0;
        case (state)
            S_IDLE: begin
                if (vsync) begin
                    state_next = S_VSYNC;
                    commit     = 1'b1;
                end
            end
            S_VSYNC: begin
                if (!vsync) begin
                    state_next  = S_ACTIVE;
                    frame_start = 1'b1;
                end
            end
            S_ACTIVE: begin
                if (vsync) begin
                    state_next = S_VSYNC;
                    frame_end  = 1'b1;
                    commit     = 1'b1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign frame_active = (state == S_ACTIVE);

    always_comb begin
        cfg_in           = '0;
        cfg_in.sobel_en  = cfg_sobel_en;
        cfg_in.threshold = cfg_threshold;
        cfg_in.mode      = cfg_mode;
    end

    // A write landing on the commit cycle bypasses the shadow and goes straight out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow        <= '0;
            pending       <= 1'b0;
            cfg_ack       <= 1'b0;
            act_sobel_en  <= 1'b0;
            act_threshold <= DEF_THRESHOLD;
            act_mode      <= MODE_FIXED;
        end else begin
            cfg_ack <= 1'b0;
            if (commit && cfg_valid) begin
                act_sobel_en  <= cfg_in.sobel_en;
                act_threshold <= cfg_in.threshold;
                act_mode      <= cfg_in.mode;
                cfg_ack       <= 1'b1;
                pending       <= 1'b0;
            end else if (commit && pending) begin
                act_sobel_en  <= shadow.sobel_en;
                act_threshold <= shadow.threshold;
                act_mode      <= shadow.mode;
                cfg_ack       <= 1'b1;
                pending       <= 1'b0;
            end else if (cfg_valid) begin
                shadow  <= cfg_in;
                pending <= 1'b1;
            end
        end
    end

    sobel_timing_cnt #(
        .IMG_WIDTH  (IMG_WIDTH),
        .IMG_HEIGHT (IMG_HEIGHT)
    ) u_timing (
        .clk         (clk),
        .rst_n       (rst_n),
        .active      (frame_active),
        .frame_start (frame_start),
        .frame_end   (frame_end),
        .href        (href),
        .err_clr     (err_clr),
        .col_count   (col_count),
        .row_count   (row_count),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .err_line    (err_line),
        .err_frame   (err_frame)
    );

`ifdef SOBEL_CTRL_STATS_EN
    logic [EDGE_CNT_W-1:0] edge_acc;
    logic [EDGE_CNT_W-1:0] edge_total;

    // The total is latched on the same edge that raises frame_done so both appear together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_acc   <= '0;
            edge_total <= '0;
        end else begin
            if (frame_start) begin
                edge_acc <= '0;
            end else if (frame_active && binary_valid && binary_pixel) begin
                edge_acc <= sat_inc_edge(edge_acc);
            end
            if (frame_end) begin
                edge_total <= edge_acc;
            end
        end
    end

    assign edge_count = edge_total;
`else
    logic unused_binary;
    assign unused_binary = binary_valid ^ binary_pixel;
    assign edge_count    = '0;
`endif

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Directed self-checking bench for sobel_frame_ctrl with a 640x4 frame geometry; checks the
// edge_count total when built with SOBEL_CTRL_STATS_EN and the tied-off zero otherwise.
`timescale 1ns/1ps
module tb_sobel_frame_ctrl;

    localparam int W = 640;
    localparam int H = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        vsync;
    logic        href;
    logic        cfg_valid;
    logic        cfg_sobel_en;
    logic [7:0]  cfg_threshold;
    logic [1:0]  cfg_mode;
    logic        cfg_ack;
    logic        act_sobel_en;
    logic [7:0]  act_threshold;
    logic [1:0]  act_mode;
    logic        binary_valid;
    logic        binary_pixel;
    logic        frame_active;
    logic [9:0]  col_count;
    logic [2:0]  row_count;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        err_line;
    logic        err_frame;
    logic        err_clr;
    logic [19:0] edge_count;

    int checks = 0;
    int errors = 0;
    int done_total = 0;
    int ack_total = 0;
    int done_base;
    int ack_base;
    int edge_expect;

    sobel_frame_ctrl #(
        .IMG_WIDTH     (W),
        .IMG_HEIGHT    (H),
        .DEF_THRESHOLD (8'd100)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .vsync         (vsync),
        .href          (href),
        .cfg_valid     (cfg_valid),
        .cfg_sobel_en  (cfg_sobel_en),
        .cfg_threshold (cfg_threshold),
        .cfg_mode      (cfg_mode),
        .cfg_ack       (cfg_ack),
        .act_sobel_en  (act_sobel_en),
        .act_threshold (act_threshold),
        .act_mode      (act_mode),
        .binary_valid  (binary_valid),
        .binary_pixel  (binary_pixel),
        .frame_active  (frame_active),
        .col_count     (col_count),
        .row_count     (row_count),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt),
        .err_line      (err_line),
        .err_frame     (err_frame),
        .err_clr       (err_clr),
        .edge_count    (edge_count)
    );

    always #5 clk = ~clk;

    // Pulse counters sample on the rising edge, before that edge's updates land
    always @(posedge clk) begin
        if (frame_done) done_total <= done_total + 1;
        if (cfg_ack)    ack_total  <= ack_total + 1;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic send_line(input int len, input int edges);
        for (int i = 0; i < len; i++) begin
            href         = 1'b1;
            binary_valid = (i < 50);
            binary_pixel = (i < edges) || (i >= 60 && i < 70);
            step(1);
        end
        href         = 1'b0;
        binary_valid = 1'b0;
        binary_pixel = 1'b0;
        step(4);
    endtask

    task automatic open_frame();
        vsync = 1'b1;
        step(3);
        vsync = 1'b0;
        step(3);
    endtask

    task automatic finish_vsync();
        step(2);
        vsync = 1'b0;
        step(3);
    endtask

    task automatic apply_cfg(input logic en, input logic [7:0] thr, input logic [1:0] mode);
        cfg_valid     = 1'b1;
        cfg_sobel_en  = en;
        cfg_threshold = thr;
        cfg_mode      = mode;
    endtask

    task automatic drop_cfg();
        cfg_valid     = 1'b0;
        cfg_sobel_en  = 1'b0;
        cfg_threshold = 8'd0;
        cfg_mode      = 2'd0;
    endtask

    initial begin
        rst_n = 1'b0; vsync = 1'b0; href = 1'b0; err_clr = 1'b0;
        binary_valid = 1'b0; binary_pixel = 1'b0;
        drop_cfg();
`ifdef SOBEL_CTRL_STATS_EN
        edge_expect = 37;
`else
        edge_expect = 0;
`endif
        step(2);
        check_output("rst_frame_active", 32'(frame_active), 32'd0);
        check_output("rst_act_threshold", 32'(act_threshold), 32'd100);
        check_output("rst_act_sobel_en", 32'(act_sobel_en), 32'd0);
        check_output("rst_act_mode", 32'(act_mode), 32'd0);
        check_output("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_output("rst_err_line", 32'(err_line), 32'd0);
        check_output("rst_err_frame", 32'(err_frame), 32'd0);
        check_output("rst_cfg_ack", 32'(cfg_ack), 32'd0);
        check_output("rst_frame_done", 32'(frame_done), 32'd0);
        check_output("rst_edge_count", 32'(edge_count), 32'd0);
        check_output("rst_col", 32'(col_count), 32'd0);
        check_output("rst_row", 32'(row_count), 32'd0);
        rst_n = 1'b1;
        step(2);

        // A line before the first vsync belongs to no frame
        send_line(100, 0);
        check_output("idle_row", 32'(row_count), 32'd0);
        check_output("idle_err_line", 32'(err_line), 32'd0);

        // Frames 1 and 2: clean 640x4
        done_base = done_total;
        open_frame();
        check_output("f1_active", 32'(frame_active), 32'd1);
        href = 1'b1;
        step(W);
        check_output("f1_col_full", 32'(col_count), 32'd640);
        href = 1'b0;
        step(1);
        check_output("f1_col_cleared", 32'(col_count), 32'd0);
        check_output("f1_row1", 32'(row_count), 32'd1);
        step(3);
        for (int l = 0; l < 3; l++) send_line(W, 0);
        check_output("f1_row4", 32'(row_count), 32'd4);
        vsync = 1'b1;
        step(1);
        check_output("f1_done_pulse", 32'(frame_done), 32'd1);
        check_output("f1_frame_cnt", 32'(frame_cnt), 32'd1);
        check_output("f1_inactive", 32'(frame_active), 32'd0);
        step(1);
        check_output("f1_done_low", 32'(frame_done), 32'd0);
        step(1);
        vsync = 1'b0;
        step(3);
        for (int l = 0; l < 4; l++) send_line(W, 0);
        vsync = 1'b1;
        step(1);
        check_output("f2_frame_cnt", 32'(frame_cnt), 32'd2);
        finish_vsync();
        check_output("f2_done_count", 32'(done_total - done_base), 32'd2);
        check_output("f2_err_line", 32'(err_line), 32'd0);
        check_output("f2_err_frame", 32'(err_frame), 32'd0);

        // Frame 3: mid-frame config held until the boundary
        ack_base = ack_total;
        send_line(W, 0);
        apply_cfg(1'b1, 8'd150, 2'b01);
        step(1);
        drop_cfg();
        for (int l = 0; l < 3; l++) send_line(W, 0);
        check_output("f3_thr_held", 32'(act_threshold), 32'd100);
        check_output("f3_en_held", 32'(act_sobel_en), 32'd0);
        check_output("f3_no_ack", 32'(ack_total - ack_base), 32'd0);
        vsync = 1'b1;
        step(1);
        check_output("f3_thr_new", 32'(act_threshold), 32'd150);
        check_output("f3_en_new", 32'(act_sobel_en), 32'd1);
        check_output("f3_mode_new", 32'(act_mode), 32'd1);
        check_output("f3_ack_pulse", 32'(cfg_ack), 32'd1);
        step(1);
        check_output("f3_ack_low", 32'(cfg_ack), 32'd0);
        step(1);
        vsync = 1'b0;
        step(3);
        check_output("f3_ack_count", 32'(ack_total - ack_base), 32'd1);

        // Frame 4: two writes, last one wins
        apply_cfg(1'b0, 8'd80, 2'b10);
        step(1);
        drop_cfg();
        send_line(W, 0);
        send_line(W, 0);
        apply_cfg(1'b1, 8'd120, 2'b00);
        step(1);
        drop_cfg();
        send_line(W, 0);
        send_line(W, 0);
        check_output("f4_thr_held", 32'(act_threshold), 32'd150);
        vsync = 1'b1;
        step(1);
        check_output("f4_thr_new", 32'(act_threshold), 32'd120);
        check_output("f4_mode_new", 32'(act_mode), 32'd0);
        check_output("f4_en_new", 32'(act_sobel_en), 32'd1);
        finish_vsync();
        check_output("f4_ack_count", 32'(ack_total - ack_base), 32'd2);
        check_output("f4_frame_cnt", 32'(frame_cnt), 32'd4);

        // Frame 5: write coinciding with the commit cycle goes straight out
        for (int l = 0; l < 4; l++) send_line(W, 0);
        vsync = 1'b1;
        apply_cfg(1'b0, 8'd33, 2'b01);
        step(1);
        drop_cfg();
        check_output("f5_thr_direct", 32'(act_threshold), 32'd33);
        check_output("f5_en_direct", 32'(act_sobel_en), 32'd0);
        check_output("f5_mode_direct", 32'(act_mode), 32'd1);
        check_output("f5_ack_pulse", 32'(cfg_ack), 32'd1);
        finish_vsync();

        // Frame 6: short line sets a sticky err_line; nothing left pending
        send_line(W - 1, 0);
        check_output("f6_err_line_set", 32'(err_line), 32'd1);
        for (int l = 0; l < 3; l++) send_line(W, 0);
        check_output("f6_err_line_sticky", 32'(err_line), 32'd1);
        vsync = 1'b1;
        step(1);
        check_output("f6_err_frame_clean", 32'(err_frame), 32'd0);
        check_output("f6_no_ack", 32'(cfg_ack), 32'd0);
        finish_vsync();
        check_output("f6_ack_count", 32'(ack_total - ack_base), 32'd3);
        check_output("f6_thr_kept", 32'(act_threshold), 32'd33);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check_output("f6_err_line_clr", 32'(err_line), 32'd0);

        // Frame 7: three lines only; err_clr on the same edge loses to the new error
        for (int l = 0; l < 3; l++) send_line(W, 0);
        vsync = 1'b1;
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check_output("f7_err_frame_prio", 32'(err_frame), 32'd1);
        check_output("f7_frame_cnt", 32'(frame_cnt), 32'd7);
        step(1);
        check_output("f7_err_frame_sticky", 32'(err_frame), 32'd1);
        err_clr = 1'b1;
        step(1);
        err_clr = 1'b0;
        check_output("f7_err_frame_clr", 32'(err_frame), 32'd0);
        vsync = 1'b0;
        step(3);

        // Frame 8: reset at row 2 col 300, then one full frame
        send_line(W, 0);
        send_line(W, 0);
        href = 1'b1;
        step(300);
        check_output("f8_col_300", 32'(col_count), 32'd300);
        check_output("f8_row_2", 32'(row_count), 32'd2);
        rst_n = 1'b0;
        #1;
        check_output("mid_rst_active", 32'(frame_active), 32'd0);
        check_output("mid_rst_col", 32'(col_count), 32'd0);
        check_output("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_output("mid_rst_thr", 32'(act_threshold), 32'd100);
        href = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
        check_output("post_rst_err_line", 32'(err_line), 32'd0);
        check_output("post_rst_done", 32'(frame_done), 32'd0);
        done_base = done_total;
        open_frame();
        send_line(W, 37);
        for (int l = 0; l < 3; l++) send_line(W, 0);
        vsync = 1'b1;
        step(1);
        check_output("rf_frame_cnt", 32'(frame_cnt), 32'd1);
        check_output("rf_err_line", 32'(err_line), 32'd0);
        check_output("rf_err_frame", 32'(err_frame), 32'd0);
        check_output("rf_edge_count", 32'(edge_count), 32'(edge_expect));
        finish_vsync();
        check_output("rf_done_count", 32'(done_total - done_base), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
